// File: rtl/sram_arbiter.sv
// Three-port arbiter for a single asynchronous SRAM: display read, sprite read, loader write.
// Define SRAM_ARB_RR_EN to arbitrate sprite/loader round-robin instead of sprite-first.
module sram_arbiter #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_ack,
    output logic [DATA_W-1:0] spr_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    inout  wire  [DATA_W-1:0] SRAM_DQ
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
    typedef enum logic [1:0] {PortDisp, PortSpr, PortLd} port_e;

    state_e              state_q;
    port_e               grant_q;
    port_e               grant_d;
    logic                req_any;
    logic [ADDR_W-1:0]   addr_sel;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   disp_rdata_q;
    logic [DATA_W-1:0]   spr_rdata_q;
    logic                dq_oe_q;
    logic                ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;
    logic                disp_ack_q, spr_ack_q, ld_ack_q;
`ifdef SRAM_ARB_RR_EN
    logic                rr_ld_q;  // 1: loader wins the next sprite/loader tie
`endif

    always_comb begin
        req_any = disp_req | spr_req | ld_req;
        grant_d = PortDisp;
        if (!disp_req) begin
            if (spr_req && ld_req) begin
`ifdef SRAM_ARB_RR_EN
                grant_d = rr_ld_q ? PortLd : PortSpr;
`else
                grant_d = PortSpr;
`endif
            end else if (spr_req) begin
                grant_d = PortSpr;
            end else if (ld_req) begin
                grant_d = PortLd;
            end
        end
        case (grant_d)
            PortSpr: addr_sel = spr_addr;
            PortLd:  addr_sel = ld_addr;
            default: addr_sel = disp_addr;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            grant_q      <= PortDisp;
            addr_q       <= '0;
            wdata_q      <= '0;
            disp_rdata_q <= '0;
            spr_rdata_q  <= '0;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            ub_n_q       <= 1'b1;
            lb_n_q       <= 1'b1;
            disp_ack_q   <= 1'b0;
            spr_ack_q    <= 1'b0;
            ld_ack_q     <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            rr_ld_q      <= 1'b0;
`endif
        end else begin
            disp_ack_q <= 1'b0;
            spr_ack_q  <= 1'b0;
            ld_ack_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_any) begin
                        state_q <= StAccess;
                        grant_q <= grant_d;
                        addr_q  <= addr_sel;
                        ce_n_q  <= 1'b0;
                        ub_n_q  <= 1'b0;
                        lb_n_q  <= 1'b0;
                        oe_n_q  <= (grant_d == PortLd);
                        we_n_q  <= (grant_d != PortLd);
                        dq_oe_q <= (grant_d == PortLd);
                        if (grant_d == PortLd) wdata_q <= ld_wdata;
`ifdef SRAM_ARB_RR_EN
                        if (grant_d == PortSpr) rr_ld_q <= 1'b1;
                        else if (grant_d == PortLd) rr_ld_q <= 1'b0;
`endif
                    end
                end
                StAccess: begin
                    state_q <= StDone;
                    dq_oe_q <= 1'b0;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    ub_n_q  <= 1'b1;
                    lb_n_q  <= 1'b1;
                    case (grant_q)
                        PortDisp: begin
                            disp_rdata_q <= SRAM_DQ;
                            disp_ack_q   <= 1'b1;
                        end
                        PortSpr: begin
                            spr_rdata_q <= SRAM_DQ;
                            spr_ack_q   <= 1'b1;
                        end
                        default: ld_ack_q <= 1'b1;
                    endcase
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign SRAM_DQ    = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign SRAM_ADDR  = addr_q;
    assign SRAM_CE_N  = ce_n_q;
    assign SRAM_OE_N  = oe_n_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_UB_N  = ub_n_q;
    assign SRAM_LB_N  = lb_n_q;
    assign disp_ack   = disp_ack_q;
    assign spr_ack    = spr_ack_q;
    assign ld_ack     = ld_ack_q;
    assign disp_rdata = disp_rdata_q;
    assign spr_rdata  = spr_rdata_q;

endmodule
